// File: rtl/bus_ctrl_seq_pkg.sv
// Shared types and constants for the bus control sequencer: state encoding,
// opcode classes, bus source bit positions and instruction register field positions.
package bus_ctrl_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T1W,
    T2,
    T3,
    T4,
    T5,
    T6,
    DONE
  } state_t;

  // Fixed (non-register) bus sources occupy the bits above R0..R15.
  typedef enum logic [4:0] {
    SRC_HI     = 5'd16,
    SRC_LO     = 5'd17,
    SRC_ZHI    = 5'd18,
    SRC_ZLO    = 5'd19,
    SRC_PC     = 5'd20,
    SRC_MDR    = 5'd21,
    SRC_INPORT = 5'd22,
    SRC_C      = 5'd23
  } src_idx_t;

  localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01101;
  localparam logic [4:0] OP_MUL       = 5'b01110;
  localparam logic [4:0] OP_DIV       = 5'b01111;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  function automatic logic op_is_alu(input logic [4:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

  function automatic logic op_is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_legal(input logic [4:0] op);
    return op_is_alu(op) || op_is_muldiv(op);
  endfunction

endpackage

// File: rtl/bus_src_onehot.sv
// Converts a 4-bit register index into a 16-bit one-hot select, all-zero when disabled.
module bus_src_onehot (
  input  logic        en,
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_ctrl_seq.sv
// Control sequencer for a single-bus datapath: fetch (T0..T2), decode (T3)
// and execute (T4..T6) with Moore-decoded bus selects and load strobes.
module bus_ctrl_seq
  import bus_ctrl_seq_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int SRC_COUNT = 24
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [WORD_SIZE-1:0] ir,
  input  logic                 mem_ready,
  output logic [SRC_COUNT-1:0] src_sel,
  output logic [15:0]          reg_in,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 PCin,
  output logic                 IRin,
  output logic                 MARin,
  output logic                 MDRin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 IncPC,
  output logic                 Read,
  output logic [4:0]           alu_op,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  state_t state, state_next;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       legal;
  logic       muldiv;

  logic [SRC_COUNT-1:0] src_fixed;
  logic [15:0]          src_reg;
  logic                 src_reg_en;
  logic [3:0]           src_reg_idx;
  logic                 reg_in_en;
  logic                 unused_ir;

  assign unused_ir = ^ir;
  assign legal     = op_is_legal(opcode);
  assign muldiv    = op_is_muldiv(opcode);

  // Instruction fields are captured on the edge into T3 so that every
  // output stays a pure decode of registered state through to DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      opcode  <= '0;
      ra      <= '0;
      rb      <= '0;
      rc      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      illegal <= (state == T3) && !legal;
      if (state == T2) begin
        opcode <= ir[IR_OP_MSB:IR_OP_LSB];
        ra     <= ir[IR_RA_MSB:IR_RA_LSB];
        rb     <= ir[IR_RB_MSB:IR_RB_LSB];
        rc     <= ir[IR_RC_MSB:IR_RC_LSB];
      end
    end
  end

  always_comb begin
    state_next  = state;
    src_fixed   = '0;
    src_reg_en  = 1'b0;
    src_reg_idx = '0;
    reg_in_en   = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    PCin        = 1'b0;
    IRin        = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    IncPC       = 1'b0;
    Read        = 1'b0;
    alu_op      = '0;
    busy        = (state != IDLE);
    done        = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          state_next = T0;
        end
      end
      T0: begin
        src_fixed[SRC_PC] = 1'b1;
        MARin             = 1'b1;
        IncPC             = 1'b1;
        Zin               = 1'b1;
        state_next        = T1;
      end
      T1: begin
        src_fixed[SRC_ZLO] = 1'b1;
        PCin               = 1'b1;
        Read               = 1'b1;
        MDRin              = 1'b1;
        state_next         = mem_ready ? T2 : T1W;
      end
      // Memory wait has no timeout; the read stays requested until ready.
      T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) begin
          state_next = T2;
        end
      end
      T2: begin
        src_fixed[SRC_MDR] = 1'b1;
        IRin               = 1'b1;
        state_next         = T3;
      end
      T3: begin
        if (legal) begin
          src_reg_en  = 1'b1;
          src_reg_idx = rb;
          Yin         = 1'b1;
          state_next  = T4;
        end else begin
          state_next = IDLE;
        end
      end
      T4: begin
        src_reg_en  = 1'b1;
        src_reg_idx = rc;
        Zin         = 1'b1;
        alu_op      = opcode;
        state_next  = T5;
      end
      T5: begin
        src_fixed[SRC_ZLO] = 1'b1;
        if (muldiv) begin
          LOin       = 1'b1;
          state_next = T6;
        end else begin
          reg_in_en  = 1'b1;
          state_next = DONE;
        end
      end
      T6: begin
        src_fixed[SRC_ZHI] = 1'b1;
        HIin               = 1'b1;
        state_next         = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  bus_src_onehot u_src_onehot (
    .en     (src_reg_en),
    .idx    (src_reg_idx),
    .onehot (src_reg)
  );

  bus_src_onehot u_reg_in_onehot (
    .en     (reg_in_en),
    .idx    (ra),
    .onehot (reg_in)
  );

  assign src_sel = src_fixed | SRC_COUNT'(src_reg);

endmodule
